// File: rtl/divider_pkg.sv
// Shared types for the restoring divider.
package divider_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/divider_step.sv
// One restoring shift-compare-subtract step; purely combinational.
module divider_step #(
  parameter int DIVISOR = 3
) (
  input  logic [DIVISOR-1:0] rem_in,
  input  logic               bit_in,
  input  logic [DIVISOR-1:0] divisor,
  output logic [DIVISOR-1:0] rem_out,
  output logic               q_bit
);
  logic [DIVISOR:0] shifted;

  // One extra bit so the shifted remainder (< 2*divisor) never overflows.
  assign shifted = {rem_in, bit_in};
  assign q_bit   = shifted >= {1'b0, divisor};
  assign rem_out = q_bit ? DIVISOR'(shifted - {1'b0, divisor}) : shifted[DIVISOR-1:0];
endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
module divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND = 6,
  parameter int DIVISOR  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DIVIDEND-1:0] dividend,
  input  logic [DIVISOR-1:0]  divisor,
  output logic [DIVIDEND-1:0] quotient,
  output logic [DIVISOR-1:0]  remainder,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero
);
  localparam int CW = $clog2(DIVIDEND);

  state_t              state, state_nxt;
  logic [DIVIDEND-1:0] dvd_sh;
  logic [DIVISOR-1:0]  dsr, prem, rem_nxt;
  logic [CW-1:0]       cnt;
  logic                q_bit, last;

  assign last = cnt == CW'(DIVIDEND - 1);
  assign busy = state == BUSY;
  assign done = state == DONE;

  divider_step #(.DIVISOR(DIVISOR)) u_step (
    .rem_in (prem),
    .bit_in (dvd_sh[DIVIDEND-1]),
    .divisor(dsr),
    .rem_out(rem_nxt),
    .q_bit  (q_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Quotient bits shift into the vacated LSBs of the dividend register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_sh      <= '0;
      dsr         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          dvd_sh <= dividend;
          dsr    <= divisor;
          prem   <= '0;
          cnt    <= '0;
        end
        BUSY: begin
          dvd_sh <= {dvd_sh[DIVIDEND-2:0], q_bit};
          prem   <= rem_nxt;
          cnt    <= cnt + 1'b1;
          if (last) begin
            quotient    <= {dvd_sh[DIVIDEND-2:0], q_bit};
            remainder   <= rem_nxt;
            div_by_zero <= dsr == '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (DIVIDEND=6, DIVISOR=3).
module tb_divider;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] dividend = '0;
  logic [2:0] divisor = '0;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {int a; int b; int q; int r; int z;} vec_t;
  vec_t tbl[6];

  divider #(.DIVIDEND(6), .DIVISOR(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Arithmetic reference: floor division, with the divide-by-zero convention.
  function automatic void model(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin q = 63; r = a % 8; z = 1; end
    else begin q = a / b; r = a % b; z = 0; end
  endfunction

  // Issue one request, scramble the inputs after capture, and wait for done.
  // lat counts rising edges including the capture edge.
  task automatic run_op(input int a, input int b, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; dividend = 6'(a); divisor = 3'(b);
    @(negedge clk);
    start = 1'b0; dividend = 6'($urandom); divisor = 3'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_check(input string name, input int a, input int b, input int q, input int r, input int z);
    int lat, bcnt;
    run_op(a, b, lat, bcnt);
    chk({name, " latency"}, lat, 7);
    chk({name, " busy cycles"}, bcnt, 6);
    chk({name, " quotient"}, int'(quotient), q);
    chk({name, " remainder"}, int'(remainder), r);
    chk({name, " div_by_zero"}, int'(div_by_zero), z);
  endtask

  initial begin
    int q, r, z, pulses, qs, rs;

    tbl[0] = '{45, 6, 7, 3, 0};
    tbl[1] = '{63, 7, 9, 0, 0};
    tbl[2] = '{ 0, 5, 0, 0, 0};
    tbl[3] = '{ 5, 0, 63, 5, 1};
    tbl[4] = '{10, 4, 2, 2, 0};
    tbl[5] = '{20, 3, 6, 2, 0};

    repeat (2) @(negedge clk);
    chk("reset quotient", int'(quotient), 0);
    chk("reset remainder", int'(remainder), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset div_by_zero", int'(div_by_zero), 0);
    rst_n = 1'b1;

    foreach (tbl[i])
      op_check($sformatf("vec%0d %0d/%0d", i, tbl[i].a, tbl[i].b),
               tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z);

    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = int'($urandom_range(0, 63));
      b = int'($urandom_range(0, 7));
      model(a, b, q, r, z);
      op_check($sformatf("rand %0d/%0d", a, b), a, b, q, r, z);
    end

    // Start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 6'd20; divisor = 3'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 6'd9; divisor = 3'd2;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; qs = -1; rs = -1;
    repeat (20) begin
      if (done) begin pulses++; qs = int'(quotient); rs = int'(remainder); end
      @(negedge clk);
    end
    chk("busy-start done pulses", pulses, 1);
    chk("busy-start quotient", qs, 6);
    chk("busy-start remainder", rs, 2);

    // Start during the done cycle must be ignored; done is one cycle only.
    op_check("pre-done 63/7", 63, 7, 9, 0, 0);
    start = 1'b1; dividend = 6'd7; divisor = 3'd1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    repeat (15) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("done-start pulses", pulses, 0);
    chk("done-start quotient held", int'(quotient), 9);

    // Reset mid-operation aborts without a done pulse.
    start = 1'b1; dividend = 6'd45; divisor = 3'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort quotient", int'(quotient), 0);
    chk("abort remainder", int'(remainder), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort div_by_zero", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("abort done pulses", pulses, 0);
    op_check("post-reset 10/4", 10, 4, 2, 2, 0);

    // Exhaustive back-to-back sweep.
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 64; a++) begin
        int lat, bcnt;
        model(a, b, q, r, z);
        run_op(a, b, lat, bcnt);
        if (lat != 7 || int'(quotient) != q || int'(remainder) != r || int'(div_by_zero) != z) begin
          chk($sformatf("sweep %0d/%0d latency", a, b), lat, 7);
          chk($sformatf("sweep %0d/%0d quotient", a, b), int'(quotient), q);
          chk($sformatf("sweep %0d/%0d remainder", a, b), int'(remainder), r);
          chk($sformatf("sweep %0d/%0d div_by_zero", a, b), int'(div_by_zero), z);
        end else begin
          checks++;
        end
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter DIVIDEND, default 6, dividend and quotient width in bits; legal range 2..32.
REQ-002 Parameter DIVISOR, default 3, divisor and remainder width in bits; legal range 2..DIVIDEND.
REQ-003 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request; sampled on a rising clk edge while idle.
REQ-007 dividend  input  DIVIDEND  unsigned numerator, captured with start.
REQ-008 divisor  input  DIVISOR  unsigned denominator, captured with start.
REQ-009 quotient  output  DIVIDEND  unsigned floor(dividend/divisor), registered.
REQ-010 remainder  output  DIVISOR  unsigned dividend mod divisor, registered.
REQ-011 busy  output  1  high while a division is in progress.
REQ-012 done  output  1  one-cycle pulse marking valid quotient/remainder.
REQ-013 div_by_zero  output  1  high with done when the captured divisor was 0; held until next start.

Function
REQ-014 States SHALL be IDLE, BUSY and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-015 In IDLE, start=1 at a rising edge SHALL capture dividend and divisor, clear the iteration counter and enter BUSY.
REQ-016 BUSY SHALL perform one restoring shift-subtract step per cycle, MSB of dividend first, for exactly DIVIDEND cycles, using a DIVISOR+1-bit partial remainder.
REQ-017 Each step: shift the next dividend bit into the partial remainder; if the result >= divisor, subtract the divisor and set the quotient bit to 1, otherwise set it to 0.
REQ-018 done SHALL be high in the cycle that begins DIVIDEND+1 rising edges after the start-capture edge; busy SHALL be high for the DIVIDEND cycles before that.
REQ-019 quotient, remainder and div_by_zero SHALL update only on entry to DONE and hold stable until the next DONE.
REQ-020 start while BUSY or DONE SHALL be ignored and the in-flight operands SHALL be unaffected.
REQ-021 start in the same cycle as done (state DONE) SHALL be ignored; a new request is accepted only from IDLE.
REQ-022 For divisor == 0, latency SHALL be unchanged, quotient SHALL be all ones, remainder SHALL be dividend[DIVISOR-1:0], and div_by_zero SHALL be 1.
REQ-023 For a nonzero divisor, results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every operand pair.
REQ-024 Input changes after the capture edge SHALL NOT affect the result.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE and set quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, and clear all internal registers.
REQ-026 Reset asserted mid-operation SHALL abort the division with no done pulse; the first start after rst_n rises SHALL behave as from power-up.

Structure
REQ-027 Package divider_pkg SHALL hold the state enum typedef (IDLE, BUSY, DONE).
REQ-028 Sub-module divider_step SHALL be purely combinational and implement one shift-compare-subtract step (partial remainder in, dividend bit in, divisor in; new partial remainder and quotient bit out).
REQ-029 divider SHALL instantiate exactly one divider_step and hold the FSM, counter and operand/result registers.

Verification (DIVIDEND=6, DIVISOR=3)
REQ-030 45/6 -> after 7 edges: done=1, quotient=7, remainder=3, div_by_zero=0; busy high for the preceding 6 cycles.
REQ-031 63/7 -> quotient=9, remainder=0; 0/5 -> quotient=0, remainder=0.
REQ-032 5/0 -> quotient=63, remainder=5, div_by_zero=1, same latency.
REQ-033 start with 20/3 then start pulse with 9/2 while busy -> single done with quotient=6, remainder=2; second request ignored.
REQ-034 rst_n low for 1 cycle at iteration 3 -> no done pulse, outputs 0; next 10/4 -> quotient=2, remainder=2.
REQ-035 Sweep all 512 {divisor,dividend} pairs back-to-back and check each against the arithmetic model, including the divisor-0 rule.
